// File: rtl/hid_report_logger.sv
// Keyboard-state logger: captures sniffer report changes into a FIFO and streams each one as an 8N1 UART frame.
// Define HID_LOGGER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module hid_report_logger #(
  parameter int CLK_HZ     = 48000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       iCLK,
  input  logic       iRSTN,
  input  logic [7:0] iMODIFIER,
  input  logic [7:0] iKEYCODE,
  input  logic [3:0] iLEDS,
  output logic       oTXD,
  output logic       oBUSY,
  output logic       oOVERFLOW,
  output logic [7:0] oDROP_CNT
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
`ifdef HID_LOGGER_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd3;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  function automatic logic [7:0] frame_byte(input logic [19:0] f, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {4'hA, f[19:16]};
      2'd1:    b = f[15:8];
      2'd2:    b = f[7:0];
`ifdef HID_LOGGER_CHECKSUM_EN
      default: b = {4'hA, f[19:16]} ^ f[15:8] ^ f[7:0];
`else
      default: b = 8'h00;
`endif
    endcase
    return b;
  endfunction

  logic [19:0]   cur_q, last_q;
  logic [19:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [19:0]   frame_q, frame_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    tx_byte;

  logic empty, full, tick, pop, push_req, push_ok, drop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tick     = (cnt_q == CNT_MAX);
  // last_q follows cur_q unconditionally, so a rejected report is lost rather than retried
  assign push_req = (cur_q != last_q);
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    ovf_d    = ovf_q | drop;
    drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          frame_d = mem_q[rd_ptr_q[AW-1:0]];
          byte_d  = 2'd0;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // line level is derived from the next state so the pin itself is a flop
    tx_byte = frame_byte(frame_d, byte_d);
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_byte[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      cur_q    <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      txd_q    <= 1'b1;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      cur_q    <= {iLEDS, iMODIFIER, iKEYCODE};
      last_q   <= cur_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      txd_q    <= txd_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= cur_q;
    frame_q <= frame_d;
  end

  assign oTXD      = txd_q;
  assign oBUSY     = (state_q != S_IDLE) || !empty;
  assign oOVERFLOW = ovf_q;
  assign oDROP_CNT = drop_q;

endmodule

// File: tb/tb_hid_report_logger.sv
// Directed bench for hid_report_logger: decodes the UART line and checks bytes, timing and drop status.
module tb_hid_report_logger;

  localparam int DIV = 16;
`ifdef HID_LOGGER_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int F = NB * 10 * DIV;

  logic       iCLK = 1'b0;
  logic       iRSTN;
  logic [7:0] iMODIFIER, iKEYCODE;
  logic [3:0] iLEDS;
  logic       oTXD, oBUSY, oOVERFLOW;
  logic [7:0] oDROP_CNT;

  hid_report_logger #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iMODIFIER(iMODIFIER), .iKEYCODE(iKEYCODE), .iLEDS(iLEDS),
    .oTXD(oTXD), .oBUSY(oBUSY), .oOVERFLOW(oOVERFLOW), .oDROP_CNT(oDROP_CNT)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] rx_q[$];
  int         start_q[$];
  logic [7:0] sh;
  bit         dact = 0;
  int         dp = 0;
  int         k;

  // UART receiver sampling mid-bit on the falling clock edge
  always @(negedge iCLK) begin
    if (!iRSTN) begin
      dact = 0;
    end else if (!dact) begin
      if (oTXD === 1'b0) begin
        dact = 1;
        dp = 0;
        start_q.push_back(cyc);
      end
    end else begin
      dp++;
      if (dp % DIV == DIV / 2) begin
        k = dp / DIV;
        if (k == 0) chk("start_bit", oTXD, 1'b0);
        else if (k <= 8) sh[k-1] = oTXD;
        else begin
          chk("stop_bit", oTXD, 1'b1);
          rx_q.push_back(sh);
          dact = 0;
        end
      end
    end
  end

  task automatic drive(input logic [19:0] v);
    @(posedge iCLK);
    #1;
    {iLEDS, iMODIFIER, iKEYCODE} = v;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(posedge iCLK);
      #1;
      t++;
    end
    chk(tag, rx_q.size() >= n, 1'b1);
  endtask

  function automatic logic [7:0] ebyte(input logic [19:0] v, input int i);
    logic [7:0] b0;
    b0 = {4'hA, v[19:16]};
    case (i)
      0: return b0;
      1: return v[15:8];
      2: return v[7:0];
      default: return b0 ^ v[15:8] ^ v[7:0];
    endcase
  endfunction

  logic [19:0] ov [8] = '{20'h1_11_21, 20'h2_12_22, 20'h3_13_23, 20'h4_14_24,
                          20'h5_15_25, 20'h6_16_26, 20'h7_17_27, 20'h8_18_28};
  int order [6] = '{0, 1, 2, 3, 4, 7};

  initial begin
    int s, n0;
    logic [7:0] exp1 [4] = '{8'hA1, 8'h02, 8'h04, 8'hA7};
    logic [7:0] exp2 [4] = '{8'hA5, 8'h11, 8'h22, 8'h96};

    iRSTN = 1'b0;
    {iLEDS, iMODIFIER, iKEYCODE} = '0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_txd", oTXD, 1'b1);
    chk("rst_busy", oBUSY, 1'b0);
    iRSTN = 1'b1;
    @(posedge iCLK);
    #1;
    chk("rel_txd", oTXD, 1'b1);
    chk("rel_busy", oBUSY, 1'b0);
    chk("rel_drop", oDROP_CNT, 8'd0);
    chk("rel_ovf", oOVERFLOW, 1'b0);
    repeat (1000) @(posedge iCLK);
    #1;
    chk("zero_no_frame", start_q.size(), 0);

    // single report
    drive(20'h1_02_04);
    s = cyc + 3;
    wait_bytes(NB, F + 100, "single_timeout");
    for (int i = 0; i < NB; i++) chk($sformatf("single_b%0d", i), rx_q[i], exp1[i]);
    chk("single_start", start_q[0], s);
    chk("single_b1_start", start_q[1], s + 160);
    wait_until(s + F - 1);
    chk("single_busy_end", oBUSY, 1'b1);
    wait_until(s + F);
    chk("single_idle_after", oBUSY, 1'b0);
    rx_q.delete();
    start_q.delete();

    // repeat filtering
    repeat (2000) @(posedge iCLK);
    #1;
    chk("repeat_one_frame", start_q.size(), 0);

    // overflow then push on the pop cycle with the FIFO full
    for (int i = 0; i < 7; i++) begin
      drive(ov[i]);
      if (i == 0) n0 = cyc;
    end
    s = n0 + 3;
    wait_until(n0 + 8);
    chk("ovf_drop", oDROP_CNT, 8'd2);
    chk("ovf_flag", oOVERFLOW, 1'b1);
    chk("ovf_busy", oBUSY, 1'b1);
    wait_until(s + F - 1);
    {iLEDS, iMODIFIER, iKEYCODE} = ov[7];
    wait_bytes(6 * NB, 6 * F + 200, "ovf_timeout");
    wait_until(cyc + 2);
    chk("fullpop_drop", oDROP_CNT, 8'd2);
    chk("ovf_frames", rx_q.size(), 6 * NB);
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < NB; i++)
        chk($sformatf("ovf_f%0d_b%0d", f, i), rx_q[f*NB+i], ebyte(ov[order[f]], i));
    chk("ovf_first_start", start_q[0], s);
    chk("ovf_gap", start_q[NB], s + F + 1);
    wait_until(cyc + 20);
    rx_q.delete();
    start_q.delete();

    // reset mid-frame during byte 1 bit 3
    drive(20'h3_40_33);
    s = cyc + 3;
    wait_until(s + 230);
    chk("mid_pre_txd", oTXD, 1'b0);
    iRSTN = 1'b0;
    {iLEDS, iMODIFIER, iKEYCODE} = '0;
    #1;
    chk("mid_rst_txd", oTXD, 1'b1);
    chk("mid_rst_busy", oBUSY, 1'b0);
    chk("mid_rst_drop", oDROP_CNT, 8'd0);
    chk("mid_rst_ovf", oOVERFLOW, 1'b0);
    repeat (3) @(posedge iCLK);
    #1;
    iRSTN = 1'b1;
    rx_q.delete();
    start_q.delete();
    repeat (5) @(posedge iCLK);
    #1;
    chk("post_rst_quiet", start_q.size(), 0);
    drive(20'h5_11_22);
    wait_bytes(NB, F + 100, "post_rst_timeout");
    for (int i = 0; i < NB; i++) chk($sformatf("post_rst_b%0d", i), rx_q[i], exp2[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
